// File: rtl/maxpool_stream.sv
// Streaming KxK, stride-K max-pooling over raster-ordered CH-lane pixels, one row of partial maxima buffered.
// Optional MAXPOOL_RELU_EN: clamp each pooled lane to max(v, 0) before the output register.
module maxpool_stream #(
    parameter int DW    = 16,
    parameter int CH    = 4,
    parameter int K     = 3,
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*DW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*DW-1:0] out_data,
    output logic             out_last
);
    localparam int OW = IMG_W / K;
    localparam int OH = IMG_H / K;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int JW = (OW > 1) ? $clog2(OW) : 1;
    localparam int IW = (OH > 1) ? $clog2(OH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
    localparam logic [JW-1:0] OW_LAST  = JW'(OW - 1);
    localparam logic [IW-1:0] OH_LAST  = IW'(OH - 1);

    // Handshake: a beat moves on a side exactly when its valid and ready are both high in a cycle;
    // an output beat, once valid, holds data and last unchanged until out_ready takes it.
    // Column position is tracked as (kc = col%K, jc = col/K); cdone marks the trailing columns.
    logic [CW-1:0] col_q, col_d;
    logic [KW-1:0] kc_q, kc_d;
    logic [JW-1:0] jc_q, jc_d;
    logic          cdone_q, cdone_d;
    logic [RW-1:0] row_q, row_d;
    logic [KW-1:0] kr_q, kr_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          rdone_q, rdone_d;

    logic [CH*DW-1:0] hacc_q, hacc_d;
    logic [CH*DW-1:0] rowbuf_q [OW];
    logic [CH*DW-1:0] rowbuf_d [OW];
    logic             out_valid_q, out_valid_d;
    logic [CH*DW-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic             accept;
    logic             win_end;
    logic [CH*DW-1:0] rb_rd, hmax, vin, res;

    // Ties return the earlier operand a.
    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(b) > $signed(a)) ? b : a;
    endfunction

    assign in_ready  = rst_n && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_comb begin
        col_d = col_q; kc_d = kc_q; jc_d = jc_q; cdone_d = cdone_q;
        row_d = row_q; kr_d = kr_q; ir_d = ir_q; rdone_d = rdone_q;
        hacc_d      = hacc_q;
        rowbuf_d    = rowbuf_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        hmax = '0;
        vin  = '0;
        res  = '0;

        accept  = in_valid && in_ready;
        win_end = accept && (kc_q == K_LAST) && !cdone_q && !rdone_q;
        rb_rd   = rowbuf_q[jc_q];

        for (int c = 0; c < CH; c++) begin
            hmax[c*DW +: DW] = (kc_q == '0) ? in_data[c*DW +: DW]
                                            : smax(hacc_q[c*DW +: DW], in_data[c*DW +: DW]);
            vin[c*DW +: DW]  = (kr_q == '0) ? hmax[c*DW +: DW]
                                            : smax(rb_rd[c*DW +: DW], hmax[c*DW +: DW]);
`ifdef MAXPOOL_RELU_EN
            res[c*DW +: DW]  = vin[c*DW + DW - 1] ? '0 : vin[c*DW +: DW];
`else
            res[c*DW +: DW]  = vin[c*DW +: DW];
`endif
        end

        if (accept) begin
            hacc_d = hmax;
            if (col_q == COL_LAST) begin
                col_d = '0; kc_d = '0; jc_d = '0; cdone_d = 1'b0;
                if (row_q == ROW_LAST) begin
                    row_d = '0; kr_d = '0; ir_d = '0; rdone_d = 1'b0;
                end else begin
                    row_d = row_q + 1'b1;
                    if (kr_q == K_LAST) begin
                        kr_d = '0;
                        if (ir_q == OH_LAST) rdone_d = 1'b1;
                        else                 ir_d    = ir_q + 1'b1;
                    end else begin
                        kr_d = kr_q + 1'b1;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
                if (kc_q == K_LAST) begin
                    kc_d = '0;
                    if (jc_q == OW_LAST) cdone_d = 1'b1;
                    else                 jc_d    = jc_q + 1'b1;
                end else begin
                    kc_d = kc_q + 1'b1;
                end
            end
        end

        // The bottom row of a window band goes straight to the output; earlier rows fold into rowbuf.
        if (win_end) begin
            if (kr_q == K_LAST) begin
                out_valid_d = 1'b1;
                out_data_d  = res;
                out_last_d  = (ir_q == OH_LAST) && (jc_q == OW_LAST);
            end else begin
                rowbuf_d[jc_q] = vin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0; kc_q <= '0; jc_q <= '0; cdone_q <= 1'b0;
            row_q <= '0; kr_q <= '0; ir_q <= '0; rdone_q <= 1'b0;
            hacc_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            for (int j = 0; j < OW; j++) rowbuf_q[j] <= '0;
        end else begin
            col_q <= col_d; kc_q <= kc_d; jc_q <= jc_d; cdone_q <= cdone_d;
            row_q <= row_d; kr_q <= kr_d; ir_q <= ir_d; rdone_q <= rdone_d;
            hacc_q      <= hacc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            for (int j = 0; j < OW; j++) rowbuf_q[j] <= rowbuf_d[j];
        end
    end
endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream on a 7x7, K=3, 4-lane frame: window-max model, per-beat compare, pinned literals.
module tb_maxpool_stream;
    localparam int DW = 16, CH = 4, K = 3, IMG_W = 7, IMG_H = 7;
    localparam int OW = IMG_W / K, OH = IMG_H / K;
    localparam int W  = CH * DW + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CH*DW-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CH*DW-1:0] out_data;
    logic             out_last;

    always #5 clk = ~clk;

    maxpool_stream #(.DW(DW), .CH(CH), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cap_q[$];
    logic signed [DW-1:0] frame [IMG_H][IMG_W][CH];
    int ready_mode = 0;

`ifdef MAXPOOL_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check16(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [W-1:0] model_beat(input int oy, input int ox);
        logic [W-1:0] b;
        logic signed [DW-1:0] m;
        b = '0;
        for (int c = 0; c < CH; c++) begin
            m = frame[oy*K][ox*K][c];
            for (int dy = 0; dy < K; dy++)
                for (int dx = 0; dx < K; dx++)
                    if (frame[oy*K+dy][ox*K+dx][c] > m) m = frame[oy*K+dy][ox*K+dx][c];
            if (RELU && m < 0) m = '0;
            b[c*DW +: DW] = m;
        end
        b[W-1] = (oy == OH-1) && (ox == OW-1);
        return b;
    endfunction

    function automatic logic [CH*DW-1:0] pix(input int r, input int c);
        logic [CH*DW-1:0] p;
        for (int l = 0; l < CH; l++) p[l*DW +: DW] = frame[r][c][l];
        return p;
    endfunction

    // ---------------- output side ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_beat = '0;
    logic [W-1:0] exp_b;

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_rule", W'(in_ready), W'(!out_valid || out_ready));
            if (prev_stall) check("stall_hold", {out_last, out_data} | W'(!out_valid), prev_beat);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", {out_last, out_data});
                end else begin
                    exp_b = exp_q.pop_front();
                    check("pooled_beat", {out_last, out_data}, exp_b);
                end
                cap_q.push_back({out_last, out_data});
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_last, out_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- input side ----------------
    task automatic send_beat(input logic [CH*DW-1:0] d);
        bit ok;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 300);
        in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL input_timeout actual=stuck required=accepted");
        end
    endtask

    task automatic send_frame(input int gap);
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++) exp_q.push_back(model_beat(oy, ox));
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                if (gap > 0) repeat ($urandom_range(0, gap)) @(posedge clk);
                #0 send_beat(pix(r, c));
            end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check(name, W'(exp_q.size()), '0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check("reset_state", {out_valid, out_last, in_ready, out_data}, '0);
        end
        exp_q.delete();
        cap_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                frame[r][c][0] = DW'(r*IMG_W + c);
                frame[r][c][1] = DW'(-(r*IMG_W + c));
                frame[r][c][2] = DW'(1000 - 3*c + r);
                frame[r][c][3] = DW'(c*r - 20);
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                for (int l = 0; l < CH; l++) frame[r][c][l] = DW'($urandom_range(0, 65535));
    endtask

    logic [DW-1:0] neg5_exp, neg_exp, min_exp;
    bit           stall_ok;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        neg5_exp = RELU ? 16'h0000 : 16'hFFFB;
        neg_exp  = RELU ? 16'h0000 : 16'hFFFF;
        min_exp  = RELU ? 16'h0000 : 16'h8000;
        do_reset(3);

        // Ramp frame; column 6 and row 6 are trailing and must be discarded.
        fill_ramp();
        send_frame(0);
        wait_drain("ramp_drain");
        check("ramp_count", W'(cap_q.size()), W'(4));
        if (cap_q.size() == 4) begin
            check16("ramp_o0", cap_q[0][DW-1:0], 16'd16);
            check16("ramp_o1", cap_q[1][DW-1:0], 16'd19);
            check16("ramp_o2", cap_q[2][DW-1:0], 16'd37);
            check16("ramp_o3", cap_q[3][DW-1:0], 16'd40);
            check("ramp_last", W'({cap_q[0][W-1], cap_q[1][W-1], cap_q[2][W-1], cap_q[3][W-1]}), W'(4'b0001));
        end

        // Constant negative frame.
        cap_q.delete();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                for (int l = 0; l < CH; l++) frame[r][c][l] = -16'sd5;
        send_frame(0);
        wait_drain("neg_drain");
        check("neg_count", W'(cap_q.size()), W'(4));
        if (cap_q.size() == 4) begin
            check16("neg_o0", cap_q[0][DW-1:0], neg5_exp);
            check16("neg_o3_l3", cap_q[3][4*DW-1:3*DW], neg5_exp);
        end

        // Independent lanes with extreme values.
        cap_q.delete();
        fill_random();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                frame[r][c][0] = 16'sh8000;
                frame[r][c][3] = -16'sd1;
            end
        frame[1][1][3] = 16'sh7FFF;
        send_frame(0);
        wait_drain("lane_drain");
        check("lane_count", W'(cap_q.size()), W'(4));
        if (cap_q.size() == 4) begin
            check16("lane3_o0", cap_q[0][4*DW-1:3*DW], 16'h7FFF);
            check16("lane3_o1", cap_q[1][4*DW-1:3*DW], neg_exp);
            check16("lane0_o0", cap_q[0][DW-1:0], min_exp);
        end

        // Back-pressure: out_ready low for 10 cycles once the first pooled beat appears.
        fill_ramp();
        ready_mode = 2;
        fork
            send_frame(0);
            begin
                int n = 0;
                while (!out_valid && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_seen", W'(out_valid), W'(1));
                stall_ok = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (in_ready !== 1'b0) stall_ok = 1'b0;
                end
                check("stall_in_ready", W'(stall_ok), W'(1));
                ready_mode = 0;
            end
        join
        wait_drain("stall_drain");

        // Random data, random input gaps and random out_ready.
        ready_mode = 1;
        repeat (2) begin
            fill_random();
            send_frame(3);
        end
        wait_drain("rand_drain");

        // Back-to-back frames with no gap.
        ready_mode = 0;
        repeat (2) begin
            fill_random();
            send_frame(0);
        end
        wait_drain("b2b_drain");

        // Mid-frame reset after the first band has been emitted.
        fill_ramp();
        for (int ox = 0; ox < OW; ox++) exp_q.push_back(model_beat(0, ox));
        for (int i = 0; i < 30; i++) send_beat(pix(i / IMG_W, i % IMG_W));
        wait_drain("abort_drain");
        do_reset(1);
        fill_random();
        send_frame(0);
        wait_drain("post_reset_drain");
        check("post_reset_count", W'(cap_q.size()), W'(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
